// File: rtl/shift_register_seq_engine.sv
// shift_register_seq_engine
// Sequential multi-position shifter. It accepts a command (an optional
// parallel load, a shift count, a direction and a mode) through a valid/ready
// handshake. It then performs one single-position shift per clock for the
// programmed count, and pulses done for one cycle when the count is finished.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   load, load_data   optional parallel load applied at the acceptance edge
//   shift_count       number of single-position shifts (0 allowed)
//   dir               0 = toward MSB, 1 = toward LSB
//   mode              00 logical, 01 rotate, 10 arithmetic, 11 as logical
//   serial_in         fill bit for logical shifts, sampled live per shift
//   q                 register contents
//   busy, done        busy in SHIFT/DONE; done is a one-cycle completion pulse
//   shift_out         last bit shifted out, held between shifts
//   zero_flag         (only with SHREG_ZERO_FLAG_EN) registered q==0 flag
//
// Optional feature macro: SHREG_ZERO_FLAG_EN
module shift_register_seq_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             shift_out
`ifdef SHREG_ZERO_FLAG_EN
  ,
  output logic             zero_flag
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic [1:0]       mode_r;
  logic [WIDTH:0]   sh_res;   // {out bit, shifted value}
  logic [WIDTH-1:0] q_nxt;
  logic             accept;

  // One single-position shift. Returns {out_bit, new_value}.
  function automatic logic [WIDTH:0] shift_once(input logic [WIDTH-1:0] v,
                                                input logic             d,
                                                input logic [1:0]       m,
                                                input logic             si);
    logic ob;
    logic fill;
    ob = d ? v[0] : v[WIDTH-1];
    case (m)
      2'b01:   fill = ob;                          // rotate
      2'b10:   fill = d ? v[WIDTH-1] : 1'b0;       // arithmetic: sign / zero
      default: fill = si;                          // logical (11 aliases 00)
    endcase
    if (d) return {ob, fill, v[WIDTH-1:1]};
    else   return {ob, v[WIDTH-2:0], fill};
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && (state == IDLE);

  // Next register value, shared by q and the optional zero flag so both
  // change on exactly the same edges.
  always_comb begin
    sh_res = shift_once(q, dir_r, mode_r, serial_in);
    q_nxt  = q;
    if (accept && load)
      q_nxt = load_data;
    else if (state == SHIFT)
      q_nxt = sh_res[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      cnt       <= '0;
      dir_r     <= 1'b0;
      mode_r    <= 2'b00;
      shift_out <= 1'b0;
    end else begin
      q <= q_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            dir_r  <= dir;
            mode_r <= mode;
            cnt    <= shift_count;
            state  <= (shift_count == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          shift_out <= sh_res[WIDTH];
          cnt       <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHREG_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) zero_flag <= 1'b1;
    else       zero_flag <= (q_nxt == '0);
  end
`endif

endmodule

// File: tb/tb_shift_register_seq_engine.sv
// Directed bench for shift_register_seq_engine (WIDTH=8, CNT_W=4).
module tb_shift_register_seq_engine;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       load;
  logic [7:0] load_data;
  logic [3:0] shift_count;
  logic       dir;
  logic [1:0] mode;
  logic       serial_in;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       shift_out;
`ifdef SHREG_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  int errors = 0;
  int checks = 0;

  shift_register_seq_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .load       (load),
    .load_data  (load_data),
    .shift_count(shift_count),
    .dir        (dir),
    .mode       (mode),
    .serial_in  (serial_in),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .shift_out  (shift_out)
`ifdef SHREG_ZERO_FLAG_EN
    ,
    .zero_flag  (zero_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command; returns 1 time unit after the acceptance edge.
  task automatic issue(input logic ld, input logic [7:0] data, input logic [3:0] cnt,
                       input logic d, input logic [1:0] m, input logic si);
    cmd_valid   = 1'b1;
    load        = ld;
    load_data   = data;
    shift_count = cnt;
    dir         = d;
    mode        = m;
    serial_in   = si;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; load = 1'b0; load_data = 8'h00;
    shift_count = 4'd0; dir = 1'b0; mode = 2'b00; serial_in = 1'b0;

    // Test 1: reset
    #2;
    chk("rst_async_q", q, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("rst_q", q, 8'h00);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sout", shift_out, 0);

    // Test 2: left logical, fill 1
    issue(1'b1, 8'hB4, 4'd3, 1'b0, 2'b00, 1'b1);
    chk("t2_load", q, 8'hB4);
    chk("t2_busy", busy, 1);
    chk("t2_ready", cmd_ready, 0);
    tick(); chk("t2_s1", q, 8'h69); chk("t2_s1_done", done, 0);
    tick(); chk("t2_s2", q, 8'hD3); chk("t2_s2_sout", shift_out, 0);
    tick(); chk("t2_s3", q, 8'hA7); chk("t2_sout", shift_out, 1);
    chk("t2_done", done, 1);
    chk("t2_done_ready", cmd_ready, 0);
    tick(); chk("t2_done_clr", done, 0); chk("t2_ready_back", cmd_ready, 1);
    chk("t2_hold", q, 8'hA7);

    // Test 3: rotate right
    issue(1'b1, 8'h81, 4'd1, 1'b1, 2'b01, 1'b0);
    tick(); chk("t3_rot1", q, 8'hC0); chk("t3_sout", shift_out, 1);
    chk("t3_done", done, 1);
    tick();
    issue(1'b1, 8'h81, 4'd8, 1'b1, 2'b01, 1'b0);
    repeat (7) tick();
    chk("t3_rot8_busy", done, 0);
    tick(); chk("t3_rot8", q, 8'h81); chk("t3_rot8_done", done, 1);
    tick();

    // Test 4: arithmetic right and left
    issue(1'b1, 8'h90, 4'd2, 1'b1, 2'b10, 1'b0);
    tick(); chk("t4_asr1", q, 8'hC8);
    tick(); chk("t4_asr2", q, 8'hE4); chk("t4_asr_sout", shift_out, 0);
    tick();
    issue(1'b1, 8'h81, 4'd1, 1'b0, 2'b10, 1'b1);
    tick(); chk("t4_asl", q, 8'h02); chk("t4_asl_sout", shift_out, 1);
    tick();

    // Test 5: zero count, then valid held through a busy command
    issue(1'b1, 8'h5A, 4'd0, 1'b0, 2'b00, 1'b0);
    chk("t5_q", q, 8'h5A);
    chk("t5_done", done, 1);
    chk("t5_sout_held", shift_out, 1);
    tick();
    chk("t5_done_clr", done, 0);
    chk("t5_idle", cmd_ready, 1);
    chk("t5_q_hold", q, 8'h5A);
    issue(1'b1, 8'h01, 4'd2, 1'b0, 2'b00, 1'b0);
    cmd_valid = 1'b1; load = 1'b1; load_data = 8'hFF;
    shift_count = 4'd5; dir = 1'b1; mode = 2'b01; serial_in = 1'b0;
    tick(); chk("t5b_s1", q, 8'h02);
    tick(); chk("t5b_s2", q, 8'h04); chk("t5b_done", done, 1);
    cmd_valid = 1'b0;
    tick(); chk("t5b_idle", cmd_ready, 1); chk("t5b_q", q, 8'h04);
    tick(); chk("t5b_no_second", busy, 0); chk("t5b_q2", q, 8'h04);

    // Test 6: reset aborts a long command
    issue(1'b1, 8'hFF, 4'd15, 1'b0, 2'b00, 1'b1);
    repeat (5) tick();
    chk("t6_mid_busy", busy, 1);
    chk("t6_mid_q", q, 8'hFF);
    reset = 1'b1;
    #1;
    chk("t6_abort_q", q, 8'h00);
    chk("t6_abort_done", done, 0);
    chk("t6_abort_ready", cmd_ready, 1);
    chk("t6_abort_sout", shift_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("t6_rel_ready", cmd_ready, 1);
    chk("t6_rel_done", done, 0);
    issue(1'b1, 8'h3C, 4'd1, 1'b1, 2'b00, 1'b0);
    chk("t6_new_load", q, 8'h3C);
    tick(); chk("t6_new_shift", q, 8'h1E); chk("t6_new_done", done, 1);
    tick(); chk("t6_new_idle", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
